pc_branch_unit: RTL

//   Program-counter and branch stage downstream of the ALU.
//   - Latches ALU flags (z,c,n,v) into a flag register.
//   - Resolves conditional branches against those flags; targets come from a small lookup table (LUT).
//   - Advances and holds the PC through an IDLE/RUN/HALT state machine; the PC addresses instruction fetch.

---
 rtl/branch_pkg.sv | 22 ++
 rtl/pc_branch_unit_if.sv | 33 +++
 rtl/branch_lut.sv | 25 ++
 rtl/pc_branch_unit.sv | 67 ++++++
 4 files changed

// File: rtl/branch_pkg.sv
// branch_pkg: shared types, defaults and condition evaluation for pc_branch_unit
package branch_pkg;
    localparam int PC_W_DEF = 10;
    localparam int LUT_DEPTH_DEF = 16;
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    typedef enum logic [2:0] {C_AL, C_EQ, C_NE, C_LT, C_GE, C_GT, C_CS, C_VS} cond_t;
    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } flags_t;
    function automatic logic cond_true(input cond_t c, input flags_t f);
        return c == C_AL ? 1'b1 :
               c == C_EQ ? f.z :
               c == C_NE ? !f.z :
               c == C_LT ? f.n :
               c == C_GE ? !f.n :
               c == C_GT ? (!f.n && !f.z) :
               c == C_CS ? f.c : f.v;
    endfunction
endpackage

// File: rtl/pc_branch_unit_if.sv
// pc_branch_unit_if: control, flag, LUT-load and PC status signals of the branch stage
interface pc_branch_unit_if #(
    parameter int PC_W = 10,
    parameter int LUT_AW = 4
);
    logic start;
    logic flag_we;
    logic z_in;
    logic c_in;
    logic n_in;
    logic v_in;
    logic branch_en;
    logic [2:0] branch_cond;
    logic [LUT_AW-1:0] branch_idx;
    logic halt_req;
    logic lut_we;
    logic [LUT_AW-1:0] lut_waddr;
    logic [PC_W-1:0] lut_wdata;
    logic [PC_W-1:0] pc;
    logic running;
    logic done;
    logic [3:0] flags_q;
    modport master(
        output start, flag_we, z_in, c_in, n_in, v_in, branch_en, branch_cond, branch_idx,
               halt_req, lut_we, lut_waddr, lut_wdata,
        input pc, running, done, flags_q
    );
    modport slave(
        input start, flag_we, z_in, c_in, n_in, v_in, branch_en, branch_cond, branch_idx,
              halt_req, lut_we, lut_waddr, lut_wdata,
        output pc, running, done, flags_q
    );
endinterface

// File: rtl/branch_lut.sv
// branch_lut: branch-target table, one sync write port, async read, cleared by reset
module branch_lut #(
    parameter int PC_W = 10,
    parameter int LUT_DEPTH = 16,
    parameter int LUT_AW = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic we,
    input  logic [LUT_AW-1:0] waddr,
    input  logic [PC_W-1:0] wdata,
    input  logic [LUT_AW-1:0] raddr,
    output logic [PC_W-1:0] rdata
);
    logic [PC_W-1:0] mem [LUT_DEPTH];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end
    // async read sees the pre-write entry during a same-cycle write
    assign rdata = mem[raddr];
endmodule

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: PC sequencer with flag register and LUT-targeted conditional branches.
// Define BRANCH_REL_EN to treat LUT entries as signed PC-relative offsets.
module pc_branch_unit
    import branch_pkg::*;
#(
    parameter int PC_W = PC_W_DEF,
    parameter int LUT_DEPTH = LUT_DEPTH_DEF,
    parameter int LUT_AW = $clog2(LUT_DEPTH)
) (
    input logic clk,
    input logic reset,
    pc_branch_unit_if.slave bus
);
    state_t state, state_n;
    flags_t flags, flags_in, eff;
    logic [PC_W-1:0] pc_q, pc_n, lut_rd, target;
    logic take;
    branch_lut #(.PC_W(PC_W), .LUT_DEPTH(LUT_DEPTH), .LUT_AW(LUT_AW)) u_lut (
        .clk(clk),
        .reset(reset),
        .we(bus.lut_we),
        .waddr(bus.lut_waddr),
        .wdata(bus.lut_wdata),
        .raddr(bus.branch_idx),
        .rdata(lut_rd)
    );
    assign flags_in = flags_t'({bus.z_in, bus.c_in, bus.n_in, bus.v_in});
    // same-cycle flag writes are forwarded into the branch decision
    assign eff = bus.flag_we ? flags_in : flags;
    assign take = bus.branch_en && cond_true(cond_t'(bus.branch_cond), eff);
`ifdef BRANCH_REL_EN
    assign target = pc_q + lut_rd;
`else
    assign target = lut_rd;
`endif
    always_comb begin
        state_n = state;
        pc_n = pc_q;
        case (state)
            IDLE: state_n = bus.start ? RUN : IDLE;
            RUN: begin
                state_n = bus.halt_req ? HALT : RUN;
                pc_n = bus.halt_req ? pc_q : take ? target : pc_q + 1'b1;
            end
            HALT: begin
                state_n = bus.start ? RUN : HALT;
                pc_n = bus.start ? '0 : pc_q;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc_q <= '0;
            flags <= '0;
        end else begin
            state <= state_n;
            pc_q <= pc_n;
            if (bus.flag_we) flags <= flags_in;
        end
    end
    assign bus.pc = pc_q;
    assign bus.running = state == RUN;
    assign bus.done = state == HALT;
    assign bus.flags_q = flags;
endmodule
